cdc_fifo_read_stream: RTL
=========================

// Module: cdc_fifo_read_stream
// PURPOSE
// - Read-side consumer of cdc_fifo, in the read_clock domain.
// - Converts the FIFO's show-ahead empty/read_increment interface into a registered valid/ready stream.
// - Holds a 2-entry elastic buffer, so out_valid/out_data are flop outputs and full throughput (1 word/cycle) is sustained.
// - out_ready has no combinational path to fifo_read_increment.
// PARAMETERS
// - DATA_WIDTH   8   width of FIFO words and out_data
// - COUNT_WIDTH 16   width of transfer counter (only with CDC_READ_STREAM_COUNT_EN)
// PORTS
// - clock               in   1            read-domain clock; single clock, all logic on rising edge
// - reset               in   1            synchronous, active-high reset
// - fifo_empty          in   1            cdc_fifo empty flag
// - fifo_read_data      in   DATA_WIDTH   cdc_fifo read_data; valid in the same cycle whenever fifo_empty==0 (show-ahead)
// - fifo_read_increment out  1            pop strobe to cdc_fifo read_increment
// - out_valid           out  1            stream word available
// - out_ready           in   1            downstream accepts
// - out_data            out  DATA_WIDTH   stream word (head entry)
// - out_count           out  COUNT_WIDTH  accepted-transfer count (only with CDC_READ_STREAM_COUNT_EN)
// BEHAVIOUR
// - Signals: pop = fifo_read_increment; acc = out_valid & out_ready.
// - Pop rule: fifo_read_increment = !reset & !fifo_empty & (state != FULL2).
//   - Depends only on state and fifo_empty, never on out_ready.
// - States (occupancy):
//   - EMPTY0: pop -> ONE1, else stay.
//   - ONE1: pop&!acc -> FULL2; pop&acc -> ONE1 (head <= popped word); !pop&acc -> EMPTY0; else stay.
//   - FULL2: acc -> ONE1 (head <= second entry); else stay. Never pops in FULL2.
// - Data movement:
//   - Popped word loads head if buffer is empty or the head is leaving this cycle; otherwise it loads the second entry.
//   - Order strictly FIFO; no word is dropped or duplicated.
// - Outputs:
//   - out_valid = (state != EMPTY0), registered.
//   - out_data = head register; held stable while out_valid & !out_ready.
// - Latency: word at FIFO head with fifo_empty low in cycle N is popped at the edge ending N; out_valid=1 with that word in cycle N+1.
// - Throughput: with out_ready held high and FIFO non-empty, one word per cycle in ONE1 steady state.
// - Backpressure: with out_ready low, at most 2 words are pulled from the FIFO, then pop stops (FULL2).
// - Simultaneous pop and accept in ONE1: occupancy unchanged, head replaced.
// - fifo_empty asserting mid-burst: no pop; buffered words still drain normally.
// - Reset (sync, any time, incl. mid-transfer):
//   - Next edge: state=EMPTY0, out_valid=0, out_data=0, both entries cleared, out_count=0.
//   - fifo_read_increment=0 throughout reset (combinational gate).
//   - Buffered words are discarded; the FIFO pointers are reset separately by read_reset.
// CONFIGURATION
// - Macro CDC_READ_STREAM_COUNT_EN:
//   - Defined: out_count port exists; increments by 1 on every acc cycle, wraps modulo 2^COUNT_WIDTH, resets to 0.
//   - Undefined: no out_count port, no counter logic; all other behaviour identical.
// STRUCTURE
// - Package cdc_fifo_pkg holds:
//   - typedef enum logic [1:0] {EMPTY0=2'd0, ONE1=2'd1, FULL2=2'd2} cdc_read_stream_state_t.
//   - localparam CDC_READ_STREAM_DEPTH = 2.
// - Single flat module, no sub-module: state register, head/second entry regs, pop logic, optional counter.
// TESTING
// - Reset, FIFO non-empty (fifo_empty=0, data 8'hA5): fifo_read_increment=0 while reset=1; out_valid=0, out_data=0 on the first edge after reset.
// - FIFO supplies 8'h01..8'h08 back-to-back, out_ready=1: one pop per cycle; out_data 01..08 on consecutive cycles starting 1 cycle after the first pop; no gaps.
// - Same stream, out_ready=0: exactly 2 pops (01,02), then state FULL2 with pop=0. Raise out_ready: 01 then 02 then 03..., no loss or duplicate.
// - Random out_ready (50%) over 1000 words with random fifo_empty gaps: output sequence equals input sequence; out_data stable whenever valid&!ready.
// - Assert reset in FULL2 mid-burst: next cycle out_valid=0; after release, the next FIFO word (not a stale entry) is the first output.
// - With CDC_READ_STREAM_COUNT_EN, COUNT_WIDTH=4: after 17 accepts out_count=1 (wrap); after reset out_count=0.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the cdc_fifo read-side stream adapter.
package cdc_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY0 = 2'd0,
    ONE1   = 2'd1,
    FULL2  = 2'd2
  } cdc_read_stream_state_t;

  localparam int unsigned CDC_READ_STREAM_DEPTH = 2;

endpackage

// File: rtl/cdc_fifo_read_stream.sv
// Show-ahead FIFO read port to registered valid/ready stream via a 2-entry elastic buffer.
// Optional accepted-transfer counter enabled by macro CDC_READ_STREAM_COUNT_EN.
module cdc_fifo_read_stream
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_read_increment,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef CDC_READ_STREAM_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out_count
`endif
);

  if (COUNT_WIDTH == 0 || DATA_WIDTH == 0 || CDC_READ_STREAM_DEPTH != 2) begin : g_bad_param
    $error("cdc_fifo_read_stream: unsupported parameterisation");
  end

  cdc_read_stream_state_t state;
  logic [DATA_WIDTH-1:0]  tail;
  logic                   pop;
  logic                   acc;

  // Pop decision sees only occupancy and fifo_empty, keeping out_ready off this path.
  assign pop                 = !reset && !fifo_empty && (state != FULL2);
  assign acc                 = out_valid && out_ready;
  assign fifo_read_increment = pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
    end else begin
      case (state)
        EMPTY0: begin
          if (pop) begin
            out_data  <= fifo_read_data;
            out_valid <= 1'b1;
            state     <= ONE1;
          end
        end
        ONE1: begin
          if (pop && !acc) begin
            tail  <= fifo_read_data;
            state <= FULL2;
          end else if (pop && acc) begin
            out_data <= fifo_read_data;
          end else if (acc) begin
            out_valid <= 1'b0;
            state     <= EMPTY0;
          end
        end
        FULL2: begin
          if (acc) begin
            out_data <= tail;
            state    <= ONE1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY0;
        end
      endcase
    end
  end

`ifdef CDC_READ_STREAM_COUNT_EN
  // Wraps naturally modulo 2^COUNT_WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_count <= '0;
    end else if (acc) begin
      out_count <= out_count + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
